// File: rtl/gameover_banner.sv
// gameover_banner: maps pixel x/y onto the "GAME OVER" glyph slots
// and animates the banner with a letter-by-letter reveal, then a blink.
module gameover_banner #(
  parameter int BASE_X        = 257,
  parameter int BASE_Y        = 230,
  parameter int PITCH         = 14,
  parameter int REVEAL_FRAMES = 8,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        game_over,
  input  logic        restart,
  output logic [31:0] posx,
  output logic [31:0] posy,
  output logic [4:0]  select_char,
  output logic        char_en,
  output logic [1:0]  banner_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REVEAL = 2'd1,
    S_BLINK  = 2'd2
  } state_t;

  localparam int XEND = BASE_X + 9*PITCH - 5;
  localparam logic [4:0] BLANK = 5'd31;

  state_t     r_state;
  logic [7:0] r_frame_cnt;
  logic [3:0] r_reveal_cnt;
  logic       r_blink_on;

  logic [31:0] w_x;
  logic [31:0] w_y;
  logic        w_in_slot;
  logic [3:0]  w_slot;
  logic [31:0] w_posx;
  logic [4:0]  w_code;
  logic        w_y_ok;
  logic        w_vis;

  function automatic logic [4:0] slot_code(input int k);
    logic [4:0] c;
    case (k)
      0:       c = 5'd0;
      1:       c = 5'd1;
      2:       c = 5'd2;
      3:       c = 5'd8;
      5:       c = 5'd5;
      6:       c = 5'd6;
      7:       c = 5'd8;
      8:       c = 5'd7;
      default: c = BLANK;
    endcase
    return c;
  endfunction

  function automatic int slot_lo(input int k);
    return BASE_X + k*PITCH;
  endfunction

  // Last slot is clipped so the banner ends at the final glyph's right edge
  function automatic int slot_hi(input int k);
    int h;
    h = BASE_X + k*PITCH + PITCH - 1;
    if (h > XEND) h = XEND;
    return h;
  endfunction

  assign w_x = 32'(x);
  assign w_y = 32'(y);

  always_comb begin
    w_in_slot = 1'b0;
    w_slot    = 4'd0;
    w_posx    = 32'(BASE_X);
    w_code    = BLANK;
    for (int k = 0; k < 9; k++) begin
      if (w_x >= 32'(slot_lo(k)) && w_x <= 32'(slot_hi(k))) begin
        w_in_slot = 1'b1;
        w_slot    = 4'(k);
        w_posx    = 32'(slot_lo(k));
        w_code    = slot_code(k);
      end
    end
  end

  assign w_y_ok = (w_y >= 32'(BASE_Y)) && (w_y <= 32'(BASE_Y + 19));

  always_comb begin
    w_vis = 1'b0;
    case (r_state)
      S_REVEAL: w_vis = (w_slot < r_reveal_cnt);
      S_BLINK:  w_vis = r_blink_on;
      default:  w_vis = 1'b0;
    endcase
  end

  assign posx         = w_posx;
  assign posy         = 32'(BASE_Y);
  assign select_char  = w_code;
  assign char_en      = w_in_slot & w_y_ok & (w_code != BLANK) & w_vis;
  assign banner_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      r_state      <= S_IDLE;
      r_frame_cnt  <= 8'd0;
      r_reveal_cnt <= 4'd0;
      r_blink_on   <= 1'b1;
    end else begin
      case (r_state)
        S_REVEAL: begin
          if (frame_tick) begin
            if (r_frame_cnt == 8'(REVEAL_FRAMES - 1)) begin
              r_frame_cnt <= 8'd0;
              if (r_reveal_cnt == 4'd8) begin
                r_state      <= S_BLINK;
                r_reveal_cnt <= 4'd9;
                r_blink_on   <= 1'b1;
              end else begin
                r_reveal_cnt <= r_reveal_cnt + 4'd1;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        S_BLINK: begin
          if (frame_tick) begin
            if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
              r_frame_cnt <= 8'd0;
              r_blink_on  <= ~r_blink_on;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          // Encoding 3 falls here too and recovers to IDLE
          if (game_over) begin
            r_state      <= S_REVEAL;
            r_frame_cnt  <= 8'd0;
            r_reveal_cnt <= 4'd0;
            r_blink_on   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
